ring_step_scheduler: RTL and testbench
======================================

# ring_step_scheduler

Controller that owns the advance input of the team's 7-phase one-hot ring sequencer and shares it between two requesters. Each granted requester gets a burst of N consecutive advance pulses. The block keeps a one-hot mirror of the ring position and the ring's boundary marker (phase 0 or phase 6). It sits between the two client FSMs and the ring sequencer, driving the sequencer's advance input from `step`.

## Interface
- `NPHASE`, 7, ring length; one-hot phase width.
- `CNTW`, 3, width of the step-count request fields.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  2  level request per requester; held until `done` for that requester.
- `steps0`  in  CNTW  burst length for requester 0; sampled at acceptance; 0 means NPHASE (full revolution).
- `steps1`  in  CNTW  burst length for requester 1; same rules as `steps0`.
- `gnt`  out  2  one-hot grant; high for the whole burst.
- `step`  out  1  advance pulse to the ring sequencer; one per cycle while stepping.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  2  one-cycle completion pulse to the granted requester.
- `phase`  out  NPHASE  one-hot ring position mirror.
- `marker`  out  1  `phase[0] | phase[NPHASE-1]`.

## Operation
- FSM states: IDLE, RUN, DONE.
- State, owner, remaining count, priority pointer and phase are registers. `gnt`, `step`, `busy`, `done` and `marker` are decoded from registered state only; no input-to-output combinational path.

IDLE
- No `req`: stay in IDLE.
- Exactly one `req` bit high: accept that requester.
- Both high: accept the requester selected by the round-robin pointer. Pointer reset value favours requester 0.
- On acceptance, latch the owner and `remaining` = owner's `stepsX` (0 loads NPHASE), then go to RUN.

RUN
- Outputs: `gnt[owner]=1`, `step=1`, `busy=1`.
- Each RUN cycle rotates `phase` left by one; bit NPHASE-1 wraps to bit 0. `remaining` decrements.
- Leave for DONE on the cycle `remaining==1`.
- Abort: if `req[owner]` is low in a RUN cycle:
  - `step` is still 1 that cycle, because it is decoded from state.
  - Next state is IDLE.
  - No `done` pulse is issued.
  - The pointer is updated as for a completed burst.
  - `phase` keeps its reached value.

DONE
- Outputs: `done[owner]=1` for one cycle, `gnt=0`, `step=0`, `busy=1`.
- Pointer moves to favour the other requester.
- Next state is IDLE.

General rules
- `phase` changes only on a `step` cycle. It always holds exactly one bit set.
- `req` of the non-owner is ignored while busy.
- `stepsX` changes after acceptance have no effect on the current burst.

## Timing
- Reset (async assert, `rst=0`):
  - State IDLE, `phase=7'b0000001`, `marker=1`.
  - `gnt=0`, `step=0`, `busy=0`, `done=0`.
  - `remaining=0`; pointer favours requester 0.
- Release is synchronous to the next `clk` edge.
- Burst timeline, with acceptance sampled in IDLE at edge t:
  - Cycles t+1 … t+N: RUN, `gnt` and `step` high.
  - Cycle t+N+1: DONE, `done` pulse.
  - Cycle t+N+2: IDLE.
  - Earliest next RUN is t+N+3.
- Phase after a completed burst starting at phase k is (k+N) mod NPHASE.
- Reset mid-RUN immediately forces all outputs and `phase` to their reset values, with no `done` pulse.

## Test plan
- Reset:
  - Assert `rst=0` mid-cycle → all outputs at reset values asynchronously; `phase=0000001`, `marker=1`.
  - Release, no `req` for 10 cycles → stays IDLE, `busy=0`.
- Single burst:
  - `req=01`, `steps0=3` from phase 0 → `gnt=01`, 3 `step` cycles.
  - `phase` goes 0000010, 0000100, 0001000.
  - `done=01` one cycle after the last step; `marker` low after the first step.
- Contention round-robin:
  - `req=11` held, `steps0=2`, `steps1=2` → grants in the order 01, 10, 01.
  - Each grant is followed by its `done`, and the two grants are separated by exactly one IDLE cycle.
- Full revolution and wrap:
  - `steps1=0` from phase 0 → 7 `step` pulses; `phase` returns to 0000001.
  - `marker` is high at the phase-6 step and again at the end.
- Abort:
  - Drop `req[0]` during step 2 of a 5-step burst → no `done`; IDLE next cycle.
  - `phase` shows 2 or 3 steps advanced, per the decoded-step rule.
  - A pending `req[1]` is granted next.
- Reset mid-run:
  - Assert `rst` during step 4 of a 6-step burst → `gnt`, `step`, `busy` drop immediately; `phase=0000001`; no `done`.

Source files
------------

// File: rtl/ring_step_scheduler.sv
// ring_step_scheduler
// Shares the advance input of the 7-phase one-hot ring sequencer between two
// requesters. The granted requester gets a burst of N advance pulses. A one-hot
// mirror of the ring position and its boundary marker are kept alongside.
// All outputs are decoded from registered state only.

module ring_step_scheduler #(
    parameter int NPHASE = 7,
    parameter int CNTW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [CNTW-1:0]   steps0,
    input  logic [CNTW-1:0]   steps1,
    output logic [1:0]        gnt,
    output logic              step,
    output logic              busy,
    output logic [1:0]        done,
    output logic [NPHASE-1:0] phase,
    output logic              marker
);

    // The remaining counter must hold both any request value and NPHASE itself,
    // because a request of 0 stands for a full revolution.
    localparam int PW = $clog2(NPHASE + 1);
    localparam int RW = (CNTW > PW) ? CNTW : PW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              ptr;
    logic [RW-1:0]     remaining;

    logic              accept_owner;
    logic [CNTW-1:0]   sel_steps;
    logic [RW-1:0]     load_val;
    logic              owner_req;

    // Choose which requester wins in IDLE and how long its burst will be.
    always_comb begin
        accept_owner = 1'b0;
        if (req == 2'b11) begin
            accept_owner = ptr;
        end else begin
            accept_owner = req[1];
        end
        sel_steps = accept_owner ? steps1 : steps0;
        if (sel_steps == '0) begin
            load_val = RW'(NPHASE);
        end else begin
            load_val = RW'(sel_steps);
        end
        owner_req = owner ? req[1] : req[0];
    end

    // Main sequencing: acceptance, burst stepping with abort, completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            ptr       <= 1'b0;
            remaining <= '0;
            phase     <= {{(NPHASE-1){1'b0}}, 1'b1};
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner     <= accept_owner;
                        remaining <= load_val;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    phase     <= {phase[NPHASE-2:0], phase[NPHASE-1]};
                    remaining <= remaining - RW'(1);
                    if (!owner_req) begin
                        ptr   <= ~owner;
                        state <= IDLE;
                    end else if (remaining == RW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        gnt    = 2'b00;
        done   = 2'b00;
        step   = 1'b0;
        busy   = (state != IDLE);
        marker = phase[0] | phase[NPHASE-1];
        if (state == RUN) begin
            step       = 1'b1;
            gnt[owner] = 1'b1;
        end
        if (state == DONE) begin
            done[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_step_scheduler.sv
// Self-checking bench for ring_step_scheduler: table-driven burst/contention
// vectors plus hand-written sequences for revolution, abort and mid-run reset.

module tb_ring_step_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [2:0] steps0;
    logic [2:0] steps1;
    logic [1:0] gnt;
    logic       step;
    logic       busy;
    logic [1:0] done;
    logic [6:0] phase;
    logic       marker;

    int tests;
    int fails;

    typedef struct {
        logic       rst_before;
        logic [1:0] req;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] gnt;
        logic       step;
        logic       busy;
        logic [1:0] done;
        logic [6:0] phase;
    } vec_t;

    vec_t vecs[$];

    ring_step_scheduler #(.NPHASE(7), .CNTW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .steps0 (steps0),
        .steps1 (steps1),
        .gnt    (gnt),
        .step   (step),
        .busy   (busy),
        .done   (done),
        .phase  (phase),
        .marker (marker)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [2:0] a,
                                input logic [2:0] b, input logic [1:0] g, input logic st,
                                input logic bz, input logic [1:0] d, input logic [6:0] ph);
        vec_t v;
        v.rst_before = r;
        v.req   = rq;
        v.s0    = a;
        v.s1    = b;
        v.gnt   = g;
        v.step  = st;
        v.busy  = bz;
        v.done  = d;
        v.phase = ph;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] eg, input logic es,
                               input logic eb, input logic [1:0] ed, input logic [6:0] ep);
        checkVal({tag, " gnt"},    int'(gnt),    int'(eg));
        checkVal({tag, " step"},   int'(step),   int'(es));
        checkVal({tag, " busy"},   int'(busy),   int'(eb));
        checkVal({tag, " done"},   int'(done),   int'(ed));
        checkVal({tag, " phase"},  int'(phase),  int'(ep));
        checkVal({tag, " marker"}, int'(marker), int'(ep[0] | ep[6]));
    endtask

    task automatic applyReset();
        rst = 1'b0;
        req = 2'b00;
        tick();
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] rq, input logic [2:0] a, input logic [2:0] b);
        req    = rq;
        steps0 = a;
        steps1 = b;
        tick();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        req    = 2'b00;
        steps0 = 3'd0;
        steps1 = 3'd0;

        // Async reset assertion between clock edges.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset async", 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);
        tick();
        rst = 1'b1;

        // Idle with no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("idle%0d", i), 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);
        end

        // Single burst of 3 from phase 0.
        vecs.push_back(mk(1, 2'b01, 3'd3, 3'd0, 2'b01, 1, 1, 2'b00, 7'b0000001));
        vecs.push_back(mk(0, 2'b01, 3'd3, 3'd0, 2'b01, 1, 1, 2'b00, 7'b0000010));
        vecs.push_back(mk(0, 2'b01, 3'd3, 3'd0, 2'b01, 1, 1, 2'b00, 7'b0000100));
        vecs.push_back(mk(0, 2'b01, 3'd3, 3'd0, 2'b00, 0, 1, 2'b01, 7'b0001000));
        vecs.push_back(mk(0, 2'b00, 3'd3, 3'd0, 2'b00, 0, 0, 2'b00, 7'b0001000));
        // Contention with both held: 01, 10, 01, then everyone drops (abort).
        vecs.push_back(mk(1, 2'b11, 3'd2, 3'd2, 2'b01, 1, 1, 2'b00, 7'b0000001));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b01, 1, 1, 2'b00, 7'b0000010));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b00, 0, 1, 2'b01, 7'b0000100));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b00, 0, 0, 2'b00, 7'b0000100));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b10, 1, 1, 2'b00, 7'b0000100));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b10, 1, 1, 2'b00, 7'b0001000));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b00, 0, 1, 2'b10, 7'b0010000));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b00, 0, 0, 2'b00, 7'b0010000));
        vecs.push_back(mk(0, 2'b11, 3'd2, 3'd2, 2'b01, 1, 1, 2'b00, 7'b0010000));
        vecs.push_back(mk(0, 2'b00, 3'd2, 3'd2, 2'b00, 0, 0, 2'b00, 7'b0100000));
        vecs.push_back(mk(0, 2'b00, 3'd2, 3'd2, 2'b00, 0, 0, 2'b00, 7'b0100000));

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) applyReset();
            applyStimulus(vecs[i].req, vecs[i].s0, vecs[i].s1);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].step, vecs[i].busy,
                        vecs[i].done, vecs[i].phase);
        end

        // Full revolution: steps1=0 means 7 steps, phase returns home.
        applyReset();
        applyStimulus(2'b10, 3'd5, 3'd0);
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("rev step%0d", k), 2'b10, 1'b1, 1'b1, 2'b00, 7'b0000001 << k);
            tick();
        end
        checkOutput("rev done", 2'b00, 1'b0, 1'b1, 2'b10, 7'b0000001);
        req = 2'b00;
        tick();
        checkOutput("rev idle", 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);

        // Abort requester 0 during step 2 of 5; pending requester 1 follows.
        applyReset();
        applyStimulus(2'b11, 3'd5, 3'd3);
        checkOutput("abort s1", 2'b01, 1'b1, 1'b1, 2'b00, 7'b0000001);
        tick();
        checkOutput("abort s2", 2'b01, 1'b1, 1'b1, 2'b00, 7'b0000010);
        applyStimulus(2'b10, 3'd5, 3'd3);
        checkOutput("abort idle", 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000100);
        tick();
        checkOutput("abort next gnt", 2'b10, 1'b1, 1'b1, 2'b00, 7'b0000100);
        // Shrinking steps1 after acceptance must not shorten the burst.
        steps1 = 3'd1;
        tick();
        checkOutput("abort b2", 2'b10, 1'b1, 1'b1, 2'b00, 7'b0001000);
        tick();
        checkOutput("abort b3", 2'b10, 1'b1, 1'b1, 2'b00, 7'b0010000);
        tick();
        checkOutput("abort b done", 2'b00, 1'b0, 1'b1, 2'b10, 7'b0100000);

        // Reset during step 4 of a 6-step burst.
        applyReset();
        applyStimulus(2'b01, 3'd6, 3'd0);
        tick();
        tick();
        tick();
        checkOutput("midrst s4", 2'b01, 1'b1, 1'b1, 2'b00, 7'b0001000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst async", 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst hold%0d", i), 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);
        end
        req = 2'b00;
        rst = 1'b1;
        tick();
        checkOutput("midrst release", 2'b00, 1'b0, 1'b0, 2'b00, 7'b0000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
